alu_seq: RTL and testbench

Parametrised, multi-cycle successor to the combinational team ALU. Accepts one operation per valid/ready handshake, computes add/sub/logic/shift in one cycle and multiply/divide iteratively in WIDTH cycles, and holds a registered result with zero/error flags until the consumer takes it. Sits between the instruction decode/register-read stage and writeback, and allows the core to close timing without a full-width combinational multiplier or divider.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_iter_core.sv | 80 ++++++++
 rtl/alu_seq.sv | 131 +++++++++++++
 tb/tb_alu_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   OP_W    : opcode width
//   op_e    : opcode encoding
//   state_e : top-level FSM states
package alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_MUL = 4'b0010,
    OP_DIV = 4'b0011,
    OP_AND = 4'b0100,
    OP_OR  = 4'b0101,
    OP_XOR = 4'b0110,
    OP_SHL = 4'b0111,
    OP_SHR = 4'b1000
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/alu_iter_core.sv
// alu_iter_core: shared iterative datapath, one step per cycle for WIDTH cycles.
//   MUL: shift-add, hi:lo starts as 0:a, ends as the 2W product.
//   DIV: restoring division, hi:lo starts as 0:a, ends as remainder:quotient.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start_i    : load operands and begin (ignored while busy)
//   is_div_i   : 1 = divide, 0 = multiply (captured on start_i)
//   a_i, b_i   : multiplier/dividend, multiplicand/divisor
//   done_o     : the current cycle performs the final step
//   result_o   : value the final step produces (valid while done_o)
module alu_iter_core #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               is_div_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q;
  logic             div_q, busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   sum, shifted, diff;

  always_comb begin
    // Multiply step: conditionally add multiplicand, then shift hi:lo right.
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    // Divide step: shift remainder:dividend left, trial-subtract divisor.
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff    = shifted - {1'b0, b_q};
    hi_d    = '0;
    lo_d    = '0;
    if (div_q) begin
      // Remainder stays below the divisor, so W bits always suffice.
      if (!diff[WIDTH]) begin
        hi_d = diff[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = shifted[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_d = sum[WIDTH:1];
      lo_d = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign done_o   = busy_q && (cnt_q == '0);
  assign result_o = {hi_d, lo_d};

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      div_q  <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i && !busy_q) begin
      hi_q   <= '0;
      lo_q   <= a_i;
      b_q    <= b_i;
      div_q  <= is_div_i;
      busy_q <= 1'b1;
      cnt_q  <= CNT_W'(WIDTH - 1);
    end else if (busy_q) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == '0) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready on both sides.
//   Single-cycle ops (add/sub/logic/shift/errors) register their result on
//   the accepting edge; MUL/DIV run WIDTH steps in alu_iter_core first.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in1, in2, op        : operands and opcode, captured on acceptance
//   in_valid / in_ready : request handshake (in_ready = idle)
//   out, zero, error    : registered result and flags
//   out_valid/out_ready : result handshake (out_valid = done)
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic [OP_W-1:0]    op,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               zero,
  output logic               error,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int SH_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] out_q, out_d;
  logic               zero_q, zero_d, error_q, error_d;
  logic [2*WIDTH-1:0] single_res;
  logic               single_err;
  logic               core_start, core_is_div, core_done;
  logic [2*WIDTH-1:0] core_result;
  op_e                op_sel;

  assign op_sel = op_e'(op);

  // Results for every op that completes on the accepting edge.
  always_comb begin
    single_res = '0;
    single_err = 1'b0;
    case (op_sel)
      OP_ADD: single_res = {{(WIDTH-1){1'b0}}, {1'b0, in1} + {1'b0, in2}};
      OP_SUB: single_res = {{WIDTH{in1 < in2}}, in1 - in2};
      OP_AND: single_res = {{WIDTH{1'b0}}, in1 & in2};
      OP_OR:  single_res = {{WIDTH{1'b0}}, in1 | in2};
      OP_XOR: single_res = {{WIDTH{1'b0}}, in1 ^ in2};
      OP_SHL: single_res = {{WIDTH{1'b0}}, in1 << in2[SH_W-1:0]};
      OP_SHR: single_res = {{WIDTH{1'b0}}, in1 >> in2[SH_W-1:0]};
      OP_MUL: single_res = '0;
      OP_DIV: single_err = 1'b1;  // only reaches this path when in2 == 0
      default: single_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    zero_d      = zero_q;
    error_d     = error_q;
    core_start  = 1'b0;
    core_is_div = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (op_sel == OP_MUL) begin
            core_start = 1'b1;
            state_d    = ST_MUL;
          end else if (op_sel == OP_DIV && in2 != '0) begin
            core_start  = 1'b1;
            core_is_div = 1'b1;
            state_d     = ST_DIV;
          end else begin
            out_d   = single_res;
            zero_d  = (single_res == '0);
            error_d = single_err;
            state_d = ST_DONE;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (core_done) begin
          out_d   = core_result;
          zero_d  = (core_result == '0);
          error_d = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      zero_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      error_q <= error_d;
    end
  end

  alu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .start_i  (core_start),
    .is_div_i (core_is_div),
    .a_i      (in1),
    .b_i      (in2),
    .done_o   (core_done),
    .result_o (core_result)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out       = out_q;
  assign zero      = zero_q;
  assign error     = error_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed results for alu_seq, WIDTH=8.
// Latency is counted as the number of rising edges after the accepting edge
// up to and including the first edge that samples out_valid high.
module tb_alu_seq;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   in1 = '0;
  logic [W-1:0]   in2 = '0;
  logic [3:0]     op = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*W-1:0] out;
  logic           zero;
  logic           error;
  logic           out_valid;
  logic           out_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in1       (in1),
    .in2       (in2),
    .op        (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .zero      (zero),
    .error     (error),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a request and return #1 after the accepting edge.
  task automatic accept(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag);
    int n;
    @(negedge clk);
    op = o; in1 = a; in2 = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check({tag, " accept timeout"}, 32'd1, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Later input changes must not disturb a captured operation.
    in1 = ~a; in2 = ~b; op = 4'b0100;
  endtask

  task automatic wait_result(input int exp_lat, input string tag);
    int cnt;
    cnt = 0;
    while (!out_valid && cnt < 50) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check({tag, " latency"}, cnt + 1, exp_lat);
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [15:0] exp_out,
                        input logic exp_zero, input logic exp_err, input int exp_lat);
    accept(o, a, b, tag);
    wait_result(exp_lat, tag);
    check({tag, " out"}, 32'(out), 32'(exp_out));
    check({tag, " zero"}, 32'(zero), 32'(exp_zero));
    check({tag, " error"}, 32'(error), 32'(exp_err));
    $display("op=%b a=0x%02h b=0x%02h -> out=0x%04h zero=%0b error=%0b (%s)",
             o, a, b, out, zero, error, tag);
    consume();
    check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out", 32'(out), 32'd0);
    check("rst zero", 32'(zero), 32'd0);
    check("rst error", 32'(error), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("add 10+5",    4'b0000, 8'd10,  8'd5,   16'h000F, 1'b0, 1'b0, 1);
    run_op("add 200+100", 4'b0000, 8'd200, 8'd100, 16'h012C, 1'b0, 1'b0, 1);
    run_op("sub 5-5",     4'b0001, 8'd5,   8'd5,   16'h0000, 1'b1, 1'b0, 1);
    run_op("sub 5-10",    4'b0001, 8'd5,   8'd10,  16'hFFFB, 1'b0, 1'b0, 1);
    run_op("mul 200*200", 4'b0010, 8'd200, 8'd200, 16'h9C40, 1'b0, 1'b0, 9);
    run_op("mul 255*255", 4'b0010, 8'd255, 8'd255, 16'hFE01, 1'b0, 1'b0, 9);
    run_op("mul 0*77",    4'b0010, 8'd0,   8'd77,  16'h0000, 1'b1, 1'b0, 9);
    run_op("div 100/7",   4'b0011, 8'd100, 8'd7,   16'h020E, 1'b0, 1'b0, 9);
    run_op("div 255/16",  4'b0011, 8'd255, 8'd16,  16'h0F0F, 1'b0, 1'b0, 9);
    run_op("div 10/0",    4'b0011, 8'd10,  8'd0,   16'h0000, 1'b1, 1'b1, 1);
    run_op("op 1111",     4'b1111, 8'd3,   8'd4,   16'h0000, 1'b1, 1'b1, 1);
    run_op("and",         4'b0100, 8'hF0,  8'h3C,  16'h0030, 1'b0, 1'b0, 1);
    run_op("or",          4'b0101, 8'hF0,  8'h3C,  16'h00FC, 1'b0, 1'b0, 1);
    run_op("xor",         4'b0110, 8'hF0,  8'h3C,  16'h00CC, 1'b0, 1'b0, 1);
    run_op("shl by 9",    4'b0111, 8'h81,  8'd9,   16'h0002, 1'b0, 1'b0, 1);
    run_op("shr by 7",    4'b1000, 8'h80,  8'd7,   16'h0001, 1'b0, 1'b0, 1);

    // Backpressure: result held for 5 cycles while a new request waits.
    accept(4'b0010, 8'd200, 8'd200, "bp mul");
    wait_result(9, "bp mul");
    @(negedge clk);
    op = 4'b0000; in1 = 8'd1; in2 = 8'd1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp hold out", 32'(out), 32'h9C40);
      check("bp hold valid", 32'(out_valid), 32'd1);
      check("bp hold zero", 32'(zero), 32'd0);
      check("bp hold error", 32'(error), 32'd0);
      check("bp hold in_ready", 32'(in_ready), 32'd0);
    end
    $display("backpressure: held out=0x%04h for 5 cycles", out);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp release valid", 32'(out_valid), 32'd0);
    check("bp release in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp next valid", 32'(out_valid), 32'd1);
    check("bp next out", 32'(out), 32'h0002);
    $display("backpressure: queued add accepted one cycle after release, out=0x%04h", out);
    consume();

    // Reset during the fourth divide iteration discards the operation.
    accept(4'b0011, 8'd100, 8'd7, "rst div");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid rst in_ready", 32'(in_ready), 32'd1);
    check("mid rst out_valid", 32'(out_valid), 32'd0);
    check("mid rst out", 32'(out), 32'd0);
    $display("reset mid-div: in_ready=%0b out_valid=%0b out=0x%04h", in_ready, out_valid, out);
    @(negedge clk);
    rst = 1'b0;
    run_op("add 1+1 after rst", 4'b0000, 8'd1, 8'd1, 16'h0002, 1'b0, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
